// File: rtl/wb_decoder_pkg.sv
// Shared definitions for the Wishbone slave decoder: bus widths, the latched
// request payload, FSM state encoding and a saturating error-count helper.
package wb_decoder_pkg;

  localparam int unsigned WB_AW  = 32;
  localparam int unsigned WB_DW  = 32;
  localparam int unsigned WB_SW  = WB_DW / 8;
  localparam int unsigned ERR_CW = 16;

  // Request captured from the bridge and replayed to the selected slave
  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_MISS = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Increment that sticks at all-ones
  function automatic logic [ERR_CW-1:0] sat_inc(input logic [ERR_CW-1:0] v);
    return (v == '1) ? v : v + ERR_CW'(1);
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address decoder: compares adr against every (mask, base)
// slot and reports whether any matched and the lowest matching index.
//   adr : byte address to decode
//   hit : at least one slot matched
//   idx : lowest matching slot (0 when no hit)
module wb_addr_match
  import wb_decoder_pkg::*;
#(
  parameter int unsigned                   NUM_SLAVES = 4,
  parameter int unsigned                   IW         = 2,
  parameter logic [WB_AW*NUM_SLAVES-1:0]   SLAVE_BASE = '0,
  parameter logic [WB_AW*NUM_SLAVES-1:0]   SLAVE_MASK = '0
) (
  input  logic [WB_AW-1:0] adr,
  output logic             hit,
  output logic [IW-1:0]    idx
);

  // Scan downward so the lowest matching slot is the last one assigned
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = int'(NUM_SLAVES) - 1; k >= 0; k--) begin
      if ((adr & SLAVE_MASK[WB_AW*k +: WB_AW]) == SLAVE_BASE[WB_AW*k +: WB_AW]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_slave_decoder.sv
// Routes the EPB bridge's single-pulse Wishbone request to one of NUM_SLAVES
// slaves by address, holds the slave strobe until ack/err or timeout, and
// returns a one-cycle ack/err with registered read data.
//   wb_clk_i, wb_rst_n            : clock, async active-low reset
//   m_cyc_i/m_stb_i/m_we_i/m_sel_i/m_adr_i/m_dat_i : bridge request (1-cycle pulse)
//   m_dat_o/m_ack_o/m_err_o       : response to the bridge
//   s_cyc_o/s_stb_o               : per-slave one-hot strobe
//   s_we_o/s_sel_o/s_adr_o/s_dat_o: latched request, shared by all slaves
//   s_dat_i/s_ack_i/s_err_i       : slave responses
//   err_count_o                   : saturating count of m_err_o pulses
module wb_slave_decoder
  import wb_decoder_pkg::*;
#(
  parameter int unsigned                 NUM_SLAVES = 4,
  parameter logic [WB_AW*NUM_SLAVES-1:0] SLAVE_BASE = {32'h0003_0000, 32'h0002_0000,
                                                       32'h0001_0000, 32'h0000_0000},
  parameter logic [WB_AW*NUM_SLAVES-1:0] SLAVE_MASK = {4{32'hFFFF_0000}},
  parameter int unsigned                 TIMEOUT    = 1024
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n,
  input  logic                        m_cyc_i,
  input  logic                        m_stb_i,
  input  logic                        m_we_i,
  input  logic [WB_SW-1:0]            m_sel_i,
  input  logic [WB_AW-1:0]            m_adr_i,
  input  logic [WB_DW-1:0]            m_dat_i,
  output logic [WB_DW-1:0]            m_dat_o,
  output logic                        m_ack_o,
  output logic                        m_err_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [WB_SW-1:0]            s_sel_o,
  output logic [WB_AW-1:0]            s_adr_o,
  output logic [WB_DW-1:0]            s_dat_o,
  input  logic [WB_DW*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_err_i,
  output logic [ERR_CW-1:0]           err_count_o
);

  localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t          state;
  wb_req_t         req_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   timer;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            sel_ack_c;
  logic            sel_err_c;
  logic [WB_DW-1:0] sel_dat_c;

  wb_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .IW         (IW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .adr (m_adr_i),
    .hit (hit),
    .idx (hit_idx)
  );

  // Only the latched slave's response is observed; others are ignored
  assign sel_ack_c = s_ack_i[idx_q];
  assign sel_err_c = s_err_i[idx_q];
  assign sel_dat_c = s_dat_i[WB_DW*idx_q +: WB_DW];

  assign s_stb_o = s_cyc_o;
  assign s_we_o  = req_q.we;
  assign s_sel_o = req_q.sel;
  assign s_adr_o = req_q.adr;
  assign s_dat_o = req_q.dat;

  // Request FSM with registered strobe, response and error count
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      idx_q       <= '0;
      timer       <= '0;
      s_cyc_o     <= '0;
      m_ack_o     <= 1'b0;
      m_err_o     <= 1'b0;
      m_dat_o     <= '0;
      err_count_o <= '0;
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            req_q <= '{we: m_we_i, sel: m_sel_i, adr: m_adr_i, dat: m_dat_i};
            timer <= '0;
            if (hit) begin
              state   <= ST_WAIT;
              idx_q   <= hit_idx;
              s_cyc_o <= NUM_SLAVES'(1) << hit_idx;
            end else begin
              // Decode miss answers immediately; MISS just pads the cycle
              state       <= ST_MISS;
              m_err_o     <= 1'b1;
              m_dat_o     <= '0;
              err_count_o <= sat_inc(err_count_o);
            end
          end
        end
        ST_WAIT: begin
          if (sel_err_c) begin
            state       <= ST_RESP;
            s_cyc_o     <= '0;
            m_err_o     <= 1'b1;
            m_dat_o     <= sel_dat_c;
            err_count_o <= sat_inc(err_count_o);
          end else if (sel_ack_c) begin
            state   <= ST_RESP;
            s_cyc_o <= '0;
            m_ack_o <= 1'b1;
            m_dat_o <= sel_dat_c;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state       <= ST_RESP;
            s_cyc_o     <= '0;
            m_err_o     <= 1'b1;
            err_count_o <= sat_inc(err_count_o);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_MISS: state <= ST_RESP;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Self-checking bench for wb_slave_decoder: directed vector table, reset
// abort sequence, and randomized transactions against a behavioural model.
module tb_wb_slave_decoder;

  localparam int N  = 4;
  localparam int TO = 1024;
  localparam logic [32*N-1:0] BASE = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [32*N-1:0] MASK = {4{32'hFFFF_0000}};

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic [3:0]      m_sel_i = '0;
  logic [31:0]     m_adr_i = '0, m_dat_i = '0;
  logic [31:0]     m_dat_o;
  logic            m_ack_o, m_err_o;
  logic [N-1:0]    s_cyc_o, s_stb_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [32*N-1:0] s_dat_i = '0;
  logic [N-1:0]    s_ack_i = '0, s_err_i = '0;
  logic [15:0]     err_count_o;

  always #5 clk = ~clk;

  wb_slave_decoder #(
    .NUM_SLAVES (N), .SLAVE_BASE (BASE), .SLAVE_MASK (MASK), .TIMEOUT (TO)
  ) dut (
    .wb_clk_i (clk), .wb_rst_n (rst_n),
    .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i), .m_we_i (m_we_i), .m_sel_i (m_sel_i),
    .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o), .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o), .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i), .s_err_i (s_err_i), .err_count_o (err_count_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          delay;
    int          kind;
    int          spur;
    int          e_err;
    int          e_lat;
    int          e_stb;
    logic [3:0]  e_mask;
    logic [31:0] e_dat;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                              input logic [31:0] wdat, input logic [31:0] rdat, input int delay,
                              input int kind, input int spur, input int e_err, input int e_lat,
                              input int e_stb, input logic [3:0] e_mask, input logic [31:0] e_dat);
    vec_t v;
    v.adr = adr; v.we = we; v.sel = sel; v.wdat = wdat; v.rdat = rdat;
    v.delay = delay; v.kind = kind; v.spur = spur;
    v.e_err = e_err; v.e_lat = e_lat; v.e_stb = e_stb; v.e_mask = e_mask; v.e_dat = e_dat;
    return v;
  endfunction

  // Results observed by run_txn
  int          a_lat, a_stb, a_ack, a_err, a_tail;
  logic [3:0]  a_mask;
  logic        a_stable, a_swe;
  logic [3:0]  a_ssel;
  logic [31:0] a_dat, a_sadr, a_sdat;

  // Behavioural model state
  int          exp_errs = 0;
  logic [31:0] mdat_model = '0;

  // Issue one bridge pulse at the current negedge, act as the slaves, and
  // record what the decoder did. Returns at a negedge where IDLE is expected.
  task automatic run_txn(input vec_t v);
    int  cyc;
    bit  done;
    for (int k = 0; k < N; k++)
      s_dat_i[32*k +: 32] = v.e_mask[k] ? v.rdat : (v.rdat ^ 32'((k + 1) * 32'h0101_0101));
    m_adr_i = v.adr; m_we_i = v.we; m_sel_i = v.sel; m_dat_i = v.wdat;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(negedge clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    cyc = 1; done = 1'b0;
    a_stb = 0; a_mask = '0; a_stable = 1'b1; a_ack = 0; a_err = 0; a_lat = -1; a_dat = '0;
    a_swe = 1'b0; a_ssel = '0; a_sadr = '0; a_sdat = '0;
    while (!done && cyc <= TO + 8) begin
      s_ack_i = '0; s_err_i = '0;
      if (m_ack_o || m_err_o) begin
        done = 1'b1; a_ack = int'(m_ack_o); a_err = int'(m_err_o); a_lat = cyc; a_dat = m_dat_o;
      end else begin
        if (s_cyc_o != '0) begin
          if (a_stb == 0) begin
            a_mask = s_cyc_o; a_swe = s_we_o; a_ssel = s_sel_o; a_sadr = s_adr_o; a_sdat = s_dat_o;
          end else if (s_cyc_o != a_mask) a_stable = 1'b0;
          if (s_stb_o != s_cyc_o) a_stable = 1'b0;
          if (a_stb == v.delay && v.kind != K_NONE) begin
            s_ack_i = (v.kind != K_ERR) ? s_cyc_o : '0;
            s_err_i = (v.kind != K_ACK) ? s_cyc_o : '0;
          end
          if (v.spur >= 0) s_ack_i[v.spur] = 1'b1;
          a_stb++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    s_ack_i = '0; s_err_i = '0;
    @(negedge clk);
    a_tail = int'(m_ack_o | m_err_o | (s_cyc_o != '0));
    if (v.e_mask == '0) @(negedge clk);
  endtask

  task automatic compare(input string tag, input vec_t v);
    if (v.e_err != 0) exp_errs++;
    mdat_model = v.e_dat;
    check($sformatf("%s.responded", tag), 32'(a_lat >= 0), 32'd1);
    check($sformatf("%s.latency", tag), 32'(a_lat), 32'(v.e_lat));
    check($sformatf("%s.ack", tag), 32'(a_ack), 32'(v.e_err == 0));
    check($sformatf("%s.err", tag), 32'(a_err), 32'(v.e_err != 0));
    check($sformatf("%s.strobe_mask", tag), 32'(a_mask), 32'(v.e_mask));
    check($sformatf("%s.strobe_cycles", tag), 32'(a_stb), 32'(v.e_stb));
    check($sformatf("%s.strobe_stable", tag), 32'(a_stable), 32'd1);
    check($sformatf("%s.m_dat", tag), a_dat, v.e_dat);
    check($sformatf("%s.single_pulse", tag), 32'(a_tail), 32'd0);
    check($sformatf("%s.err_count", tag), 32'(err_count_o), 32'(exp_errs));
    if (v.e_mask != '0) begin
      check($sformatf("%s.s_adr", tag), a_sadr, v.adr);
      check($sformatf("%s.s_dat", tag), a_sdat, v.wdat);
      check($sformatf("%s.s_we_sel", tag), {27'd0, a_swe, a_ssel}, {27'd0, v.we, v.sel});
    end
  endtask

  function automatic int find_slave(input logic [31:0] a);
    for (int k = 0; k < N; k++)
      if ((a & MASK[32*k +: 32]) == BASE[32*k +: 32]) return k;
    return -1;
  endfunction

  // Expected outcome derived from the decoder's rules
  function automatic vec_t model(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                                 input logic [31:0] wdat, input logic [31:0] rdat,
                                 input int delay, input int kind, input int spur);
    vec_t v;
    int   s;
    s = find_slave(adr);
    v = mk(adr, we, sel, wdat, rdat, delay, kind, spur, 0, 0, 0, 4'd0, mdat_model);
    if (s < 0) begin
      v.e_err = 1; v.e_lat = 1; v.e_stb = 0; v.e_dat = 32'd0;
    end else begin
      v.e_mask = 4'(1 << s);
      if (kind == K_NONE || delay >= TO) begin
        v.e_err = 1; v.e_lat = TO + 1; v.e_stb = TO;
      end else begin
        v.e_err = (kind == K_ACK) ? 0 : 1;
        v.e_lat = delay + 2; v.e_stb = delay + 1; v.e_dat = rdat;
      end
    end
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(32'h0002_0010, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 0, K_ACK, -1,
                0, 2, 1, 4'b0100, 32'hCAFE_F00D);
    tbl[1] = mk(32'h0001_0004, 1'b1, 4'b0011, 32'h1234_5678, 32'h0000_1111, 3, K_ACK, -1,
                0, 5, 4, 4'b0010, 32'h0000_1111);
    tbl[2] = mk(32'h0005_0000, 1'b0, 4'hF, 32'h0, 32'h7777_7777, 0, K_ACK, -1,
                1, 1, 0, 4'b0000, 32'h0);
    tbl[3] = mk(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h3333_3333, 99999, K_NONE, -1,
                1, TO + 1, TO, 4'b0001, 32'h0);
    tbl[4] = mk(32'h0003_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1, K_BOTH, 0,
                1, 3, 2, 4'b1000, 32'hDEAD_BEEF);
    tbl[5] = mk(32'h0001_FFFC, 1'b1, 4'b1000, 32'hA5A5_0000, 32'h5A5A_5A5A, 0, K_ERR, -1,
                1, 2, 1, 4'b0010, 32'h5A5A_5A5A);
    tbl[6] = mk(32'h0000_FFFF, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, TO - 1, K_ACK, -1,
                0, TO + 1, TO, 4'b0001, 32'h0BAD_F00D);
    tbl[7] = mk(32'h0004_0000, 1'b0, 4'hF, 32'h0, 32'h1, 0, K_ACK, -1,
                1, 1, 0, 4'b0000, 32'h0);
    tbl[8] = mk(32'hFFFF_0003, 1'b1, 4'hF, 32'h9, 32'h2, 0, K_ACK, -1,
                1, 1, 0, 4'b0000, 32'h0);

    // Reset state
    #12;
    check("reset.resp", {29'd0, m_ack_o, m_err_o, s_we_o}, 32'd0);
    check("reset.m_dat", m_dat_o, 32'd0);
    check("reset.strobes", {24'd0, s_cyc_o, s_stb_o}, 32'd0);
    check("reset.s_adr", s_adr_o, 32'd0);
    check("reset.s_dat", s_dat_o, 32'd0);
    check("reset.sel_cnt", {12'd0, s_sel_o, err_count_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i]);
      compare($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset while a slave is being strobed aborts the transaction silently
    begin
      int stray;
      m_adr_i = 32'h0002_0000; m_we_i = 1'b0; m_sel_i = 4'hF;
      m_cyc_i = 1'b1; m_stb_i = 1'b1;
      @(negedge clk);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_abort.pre_strobe", 32'(s_cyc_o), 32'b0100);
      #2 rst_n = 1'b0;
      #1;
      check("rst_abort.strobe_drop", 32'(s_cyc_o), 32'd0);
      check("rst_abort.err_count", 32'(err_count_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (8) begin
        @(negedge clk);
        if (m_ack_o || m_err_o || s_cyc_o != '0) stray++;
      end
      check("rst_abort.no_resp", 32'(stray), 32'd0);
      exp_errs = 0;
      mdat_model = '0;
    end
    begin
      vec_t v;
      v = model(32'h0001_0020, 1'b0, 4'hF, 32'h0, 32'h600D_D00D, 2, K_ACK, -1);
      run_txn(v);
      compare("post_reset", v);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      vec_t        v;
      logic [31:0] adr;
      int          s, spur;
      adr  = {16'($urandom_range(0, 5)), 16'($urandom)};
      s    = find_slave(adr);
      spur = -1;
      if (s >= 0 && $urandom_range(0, 1) == 1) spur = (s + 1 + int'($urandom_range(0, 2))) % N;
      v = model(adr, 1'($urandom), 4'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), spur);
      run_txn(v);
      compare($sformatf("rnd%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1, "watchdog");
  end

endmodule
